// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift-add multiplier sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } seq_state_t;

  // A requested step count of 0, or one above the operand width, means "full width".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
    if (len == 0 || len > width) begin
      return width;
    end
    return len;
  endfunction

endpackage

// File: rtl/step_counter.sv
// Step counter for the shift-add sequencer: counts completed steps and flags the final one.
module step_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_len_q,
  output logic [CNT_W-1:0] o_count,
  output logic             o_is_last
);

  logic [CNT_W-1:0] r_count;

  // Clear wins over increment; the sequencer never asserts both at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count   = r_count;
  // len_q is never 0, so the subtraction cannot underflow.
  assign o_is_last = (r_count == i_len_q - CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Control sequencer for the shift-add multiplier: start -> load strobe -> N step strobes -> done.
// Optional early exit on all-zero remaining multiplier bits is enabled by defining
// SHIFT_SEQ_EARLY_EXIT_EN; by default zero_rem is ignored and early stays 0.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_step_ok,
  input  logic             i_abort,
  input  logic             i_zero_rem,
  output logic             o_busy,
  output logic             o_load,
  output logic             o_step,
  output logic             o_last,
  output logic [CNT_W-1:0] o_count,
  output logic             o_done,
  output logic             o_early
);

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_len_q;
  logic             r_busy;
  logic             r_load;
  logic             r_done;
  logic             r_early;

  logic             w_run;
  logic             w_accept;
  logic             w_abort;
  logic             w_early_exit;
  logic             w_step;
  logic             w_is_last;
  logic             w_clr;

  assign w_run        = (r_state == StRun);
  assign w_accept     = (r_state == StIdle) && i_start;
  assign w_abort      = ((r_state == StLoad) || w_run) && i_abort;
  // Early exit outranks a step in the same cycle; abort outranks both.
  assign w_early_exit = EarlyEn && w_run && !i_abort && i_zero_rem;
  assign w_step       = w_run && i_step_ok && !i_abort && !w_early_exit;
  assign w_clr        = w_accept || w_abort;

  step_counter #(
    .CNT_W(CNT_W)
  ) u_step_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_inc    (w_step),
    .i_len_q  (r_len_q),
    .o_count  (o_count),
    .o_is_last(w_is_last)
  );

  // Sequencer FSM with registered busy/load/done/early strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_len_q <= CNT_W'(WIDTH);
      r_busy  <= 1'b0;
      r_load  <= 1'b0;
      r_done  <= 1'b0;
      r_early <= 1'b0;
    end else begin
      r_load  <= 1'b0;
      r_done  <= 1'b0;
      r_early <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= StLoad;
            r_len_q <= CNT_W'(clamp_len(32'(i_len), WIDTH));
            r_busy  <= 1'b1;
            r_load  <= 1'b1;
          end
        end
        StLoad: begin
          if (i_abort) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_state <= StRun;
          end
        end
        StRun: begin
          if (i_abort) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (w_early_exit) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_early <= 1'b1;
          end else if (w_step && w_is_last) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_load  = r_load;
  assign o_done  = r_done;
  assign o_early = r_early;
  assign o_step  = w_step;
  assign o_last  = w_step && w_is_last;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer (WIDTH=8): the driver pushes expected strobe events,
// a negedge monitor pops and compares whenever load/step/last/done appears.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [3:0] i_len;
  logic       i_step_ok;
  logic       i_abort;
  logic       i_zero_rem;
  logic       o_busy;
  logic       o_load;
  logic       o_step;
  logic       o_last;
  logic [3:0] o_count;
  logic       o_done;
  logic       o_early;

  shift_sequencer #(
    .WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_len     (i_len),
    .i_step_ok (i_step_ok),
    .i_abort   (i_abort),
    .i_zero_rem(i_zero_rem),
    .o_busy    (o_busy),
    .o_load    (o_load),
    .o_step    (o_step),
    .o_last    (o_last),
    .o_count   (o_count),
    .o_done    (o_done),
    .o_early   (o_early)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic       ld;
    logic       st;
    logic       la;
    logic       dn;
    logic       ea;
    logic       bz;
    logic [3:0] cnt;
  } ev_t;

  ev_t   sb[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  string tname = "reset";

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe the DUT presents must match the next expected event.
  always @(negedge clk) begin
    if (o_load || o_step || o_last || o_done) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s unexpected: got c=%0d ld=%b st=%b la=%b dn=%b ea=%b cnt=%0d, need none",
                 tname, cyc, o_load, o_step, o_last, o_done, o_early, o_count);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (e.c != cyc || e.ld !== o_load || e.st !== o_step || e.la !== o_last ||
            e.dn !== o_done || e.ea !== o_early || e.bz !== o_busy || e.cnt !== o_count) begin
          n_fail++;
          $display("FAIL %s event: got c=%0d ld=%b st=%b la=%b dn=%b ea=%b bz=%b cnt=%0d, need c=%0d ld=%b st=%b la=%b dn=%b ea=%b bz=%b cnt=%0d",
                   tname, cyc, o_load, o_step, o_last, o_done, o_early, o_busy, o_count,
                   e.c, e.ld, e.st, e.la, e.dn, e.ea, e.bz, e.cnt);
        end
      end
    end
  end

  task automatic ev(input int c, input logic ld, st, la, dn, ea, bz, input logic [3:0] cnt);
    ev_t e;
    e.c = c; e.ld = ld; e.st = st; e.la = la; e.dn = dn; e.ea = ea; e.bz = bz; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // n consecutive steps starting at cycle c0 with count cnt0; optionally the last one is final.
  task automatic steps(input int c0, input int cnt0, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      ev(c0 + i, 1'b0, 1'b1, with_last && (i == n - 1), 1'b0, 1'b0, 1'b1, 4'(cnt0 + i));
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h, need %0h", tname, nm, act, exp);
    end
  endtask

  // Drive n cycles; bit k of each mask applies to cycle k (step_ok is low where stl is set).
  task automatic op(input logic [3:0] len, input logic [15:0] st, stl, ab, zr, rs, input int n);
    for (int k = 0; k < n; k++) begin
      i_start    = st[k];
      i_len      = len;
      i_step_ok  = !stl[k];
      i_abort    = ab[k];
      i_zero_rem = zr[k];
      rst        = rs[k];
      @(posedge clk);
      #1;
    end
    i_start    = 1'b0;
    i_step_ok  = 1'b1;
    i_abort    = 1'b0;
    i_zero_rem = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic drained();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s drained: got %0d pending events, need 0", tname, sb.size());
      sb.delete();
    end
  endtask

  int t0;

  initial begin
    rst = 1'b1; i_start = 1'b0; i_len = 4'd0; i_step_ok = 1'b1; i_abort = 1'b0;
    i_zero_rem = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs", {27'd0, o_busy, o_load, o_step, o_last, o_done},  32'd0);
    chk("reset early", {31'd0, o_early}, 32'd0);
    chk("reset count", {28'd0, o_count}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // len=4, no stalls
    tname = "len4"; t0 = cyc;
    ev(t0 + 1, 1, 0, 0, 0, 0, 1, 0);
    steps(t0 + 2, 0, 4, 1);
    ev(t0 + 6, 0, 0, 0, 1, 0, 0, 4);
    op(4'd4, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 8);
    drained();
    chk("count holds", {28'd0, o_count}, 32'd4);

    // len=0 and len=12 both mean 8 steps
    tname = "len0"; t0 = cyc;
    ev(t0 + 1, 1, 0, 0, 0, 0, 1, 0);
    steps(t0 + 2, 0, 8, 1);
    ev(t0 + 10, 0, 0, 0, 1, 0, 0, 8);
    op(4'd0, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 12);
    drained();

    tname = "len12"; t0 = cyc;
    ev(t0 + 1, 1, 0, 0, 0, 0, 1, 0);
    steps(t0 + 2, 0, 8, 1);
    ev(t0 + 10, 0, 0, 0, 1, 0, 0, 8);
    op(4'd12, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 12);
    drained();

    // len=3 with step_ok low in cycles 3-4
    tname = "stall"; t0 = cyc;
    ev(t0 + 1, 1, 0, 0, 0, 0, 1, 0);
    ev(t0 + 2, 0, 1, 0, 0, 0, 1, 0);
    ev(t0 + 5, 0, 1, 0, 0, 0, 1, 1);
    ev(t0 + 6, 0, 1, 1, 0, 0, 1, 2);
    ev(t0 + 7, 0, 0, 0, 1, 0, 0, 3);
    op(4'd3, 16'h0001, 16'h0018, 16'h0, 16'h0, 16'h0, 9);
    drained();

    // abort in cycle 3 of len=6, then a start in cycle 4 is accepted
    tname = "abort"; t0 = cyc;
    ev(t0 + 1, 1, 0, 0, 0, 0, 1, 0);
    ev(t0 + 2, 0, 1, 0, 0, 0, 1, 0);
    op(4'd6, 16'h0001, 16'h0, 16'h0008, 16'h0, 16'h0, 4);
    chk("abort count", {28'd0, o_count}, 32'd0);
    chk("abort busy", {31'd0, o_busy}, 32'd0);
    drained();
    t0 = cyc;
    ev(t0 + 1, 1, 0, 0, 0, 0, 1, 0);
    steps(t0 + 2, 0, 2, 1);
    ev(t0 + 4, 0, 0, 0, 1, 0, 0, 2);
    op(4'd2, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 6);
    drained();

    // starts in cycles 1 and 3 while busy are ignored
    tname = "restart"; t0 = cyc;
    ev(t0 + 1, 1, 0, 0, 0, 0, 1, 0);
    steps(t0 + 2, 0, 4, 1);
    ev(t0 + 6, 0, 0, 0, 1, 0, 0, 4);
    op(4'd4, 16'h000B, 16'h0, 16'h0, 16'h0, 16'h0, 8);
    drained();

    // synchronous reset in cycle 3 mid-run
    tname = "midrst"; t0 = cyc;
    ev(t0 + 1, 1, 0, 0, 0, 0, 1, 0);
    ev(t0 + 2, 0, 1, 0, 0, 0, 1, 0);
    op(4'd4, 16'h0001, 16'h0008, 16'h0, 16'h0, 16'h0008, 4);
    chk("rst outs", {27'd0, o_busy, o_load, o_step, o_last, o_done}, 32'd0);
    chk("rst early/count", {27'd0, o_early, o_count}, 32'd0);
    op(4'd4, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4);
    drained();

    // zero_rem in cycle 5 of a len=8 run
    tname = "zerorem"; t0 = cyc;
    ev(t0 + 1, 1, 0, 0, 0, 0, 1, 0);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    steps(t0 + 2, 0, 3, 0);
    ev(t0 + 6, 0, 0, 0, 1, 1, 0, 3);
`else
    steps(t0 + 2, 0, 8, 1);
    ev(t0 + 10, 0, 0, 0, 1, 0, 0, 8);
`endif
    op(4'd8, 16'h0001, 16'h0, 16'h0, 16'h0020, 16'h0, 12);
    drained();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
